// File: rtl/bin2bcd_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding an 8-digit 7-segment display.
// A result is published only on the completion edge, so the display never shows partial digits.
module bin2bcd_display #(
  parameter logic [31:0] ERR_CODE = 32'hEEEE_EEEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [31:0] bcd_out
);

  localparam int unsigned W      = 32;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned CW     = 5;
  localparam logic [W-1:0]  MAX_DEC  = W'(99_999_999);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [W-1:0]  bcd_d;
  logic          ovf_d, done_d, busy_d;
  logic [W-1:0]  adj_work;

  // Digits >= 5 get +3 so that the following left shift carries correctly into the next decade.
  function automatic logic [W-1:0] add3(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = w;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_out;
    ovf_d      = ovf;
    done_d     = 1'b0;
    adj_work   = add3(work_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          shift_d    = bin_in;
          work_d     = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin_in > MAX_DEC);
        end
      end
      SHIFT: begin
        work_d  = {adj_work[W-2:0], shift_q[W-1]};
        shift_d = {shift_q[W-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = ovf_pend_q ? ERR_CODE : work_d;
          ovf_d   = ovf_pend_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered copy of (state != IDLE), taken from the state being entered.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_out    <= bcd_d;
      ovf        <= ovf_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed self-checking bench for bin2bcd_display: latency, results, overflow, back-to-back and async reset.
module tb_bin2bcd_display;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] bcd_out;

  int checks = 0;
  int errors = 0;

  bin2bcd_display dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, error code when out of range.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    int unsigned x;
    r = 32'h0;
    if (v > 32'd99_999_999) return 32'hEEEE_EEEE;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One conversion: start held through SHIFT (must be ignored), bin_in scrambled after accept.
  task automatic run_conv(input logic [31:0] v, input string tag);
    logic [31:0] exp_bcd;
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    logic        exp_ovf;
    int          n;
    bit          stable;
    exp_bcd = ref_bcd(v);
    exp_ovf = (v > 32'd99_999_999);
    @(negedge clk);
    prev_bcd = bcd_out;
    prev_ovf = ovf;
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    n = 0;
    stable = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (bcd_out !== prev_bcd || ovf !== prev_ovf) stable = 1'b0;
      bin_in = $urandom;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd32);
    check({tag, " stable_during_conv"}, 32'(stable), 32'd1);
    check({tag, " bcd_out"}, bcd_out, exp_bcd);
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, " done_falls"}, 32'(done), 32'd0);
    check({tag, " busy_falls"}, 32'(busy), 32'd0);
    check({tag, " bcd_hold"}, bcd_out, exp_bcd);
  endtask

  initial begin
    int          done_seen;
    int          cyc;
    int          last_acc;
    int          n_acc;
    logic        prev_busy;
    logic [31:0] pend;
    logic [31:0] drive;
    logic [31:0] rv;
    int          n;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 32'h0;
    #22;
    check("reset_bcd", bcd_out, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no start for 100 cycles
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("idle_done_never", 32'(done_seen), 32'd0);
    check("idle_bcd", bcd_out, 32'h0);
    check("idle_busy", 32'(busy), 32'd0);

    run_conv(32'd0,          "zero");
    run_conv(32'd12_345_678, "12345678");
    run_conv(32'd99_999_999, "max_dec");
    run_conv(32'd100_000_000, "ovf_min");
    run_conv(32'hFFFF_FFFF,  "ovf_max");
    run_conv(32'd42,         "after_ovf_42");

    // Start held high, bin_in changing every cycle: accepts 34 apart, results match accept-edge value
    @(negedge clk);
    start     = 1'b1;
    cyc       = 0;
    last_acc  = -1;
    n_acc     = 0;
    prev_busy = busy;
    pend      = 32'h0;
    drive     = 32'h0;
    for (int k = 0; k < 110; k++) begin
      drive  = 32'd3 + 32'(k) * 32'd876_543;
      bin_in = drive;
      @(posedge clk); #1;
      cyc++;
      if (!prev_busy && busy) begin
        if (last_acc >= 0) check("b2b_period", 32'(cyc - last_acc), 32'd34);
        last_acc = cyc;
        pend     = drive;
        n_acc++;
      end
      if (done === 1'b1) begin
        check("b2b_latency", 32'(cyc - last_acc), 32'd32);
        check("b2b_result", bcd_out, ref_bcd(pend));
      end
      prev_busy = busy;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_drain", 32'(busy), 32'd0);

    // Async reset mid-conversion after an overflow result is on display
    run_conv(32'hFFFF_FFF0, "pre_reset_ovf");
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd87_654_321;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bcd", bcd_out, 32'h0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("aborted_no_done", 32'(done_seen), 32'd0);

    // Start on the very first edge after reset release
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    run_conv(32'd87_654_321, "after_reset");

    // Small random regression against the decimal reference
    for (int i = 0; i < 12; i++) begin
      rv = (i % 4 == 3) ? $urandom : 32'($urandom_range(99_999_999, 0));
      run_conv(rv, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
